// File: rtl/smem_copy.sv
// smem_copy: pi1 bus master DMA engine that copies a block of words, read-then-write per word.
module smem_copy #(
  parameter int ARCHBITSZ = 32,
  parameter int LENBITSZ = 16,
  localparam int ADDRBITSZ = ARCHBITSZ - $clog2(ARCHBITSZ/8)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   abort_i,
  input  logic [ADDRBITSZ-1:0]   src_i,
  input  logic [ADDRBITSZ-1:0]   dst_i,
  input  logic [LENBITSZ-1:0]    len_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   aborted_o,
  output logic [LENBITSZ-1:0]    rem_o,
  output logic [1:0]             pi1_op_o,
  output logic [ADDRBITSZ-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]   pi1_data_o,
  input  logic [ARCHBITSZ-1:0]   pi1_data_i,
  output logic [ARCHBITSZ/8-1:0] pi1_sel_o,
  input  logic                   pi1_rdy_i
);
  localparam logic [1:0] OP_NOP = 2'b00, OP_WR = 2'b01, OP_RD = 2'b10;
  typedef enum logic [2:0] {IDLE, RDREQ, RDDATA, WRREQ, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDRBITSZ-1:0] src, dst;
  logic abort_q, acc, last;
  assign pi1_sel_o = '1;
  assign acc = pi1_op_o != OP_NOP && pi1_rdy_i;
  assign last = rem_o == LENBITSZ'(1) || abort_q;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start_i && len_i != '0 ? RDREQ : IDLE;
      RDREQ:   state_nx = acc ? RDDATA : RDREQ;
      RDDATA:  state_nx = pi1_rdy_i ? WRREQ : RDDATA;
      WRREQ:   state_nx = acc ? (last ? DRAIN : RDREQ) : WRREQ;
      DRAIN:   state_nx = pi1_rdy_i ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      pi1_op_o   <= OP_NOP;
      pi1_addr_o <= '0;
      pi1_data_o <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      aborted_o  <= 1'b0;
      rem_o      <= '0;
      src        <= '0;
      dst        <= '0;
      abort_q    <= 1'b0;
    end else begin
      state  <= state_nx;
      done_o <= 1'b0;
      if (busy_o && abort_i) abort_q <= 1'b1;
      case (state)
        IDLE: if (start_i) begin
          aborted_o <= 1'b0;
          abort_q   <= 1'b0;
          done_o    <= len_i == '0;
          if (len_i != '0) begin
            src        <= src_i;
            dst        <= dst_i;
            rem_o      <= len_i;
            busy_o     <= 1'b1;
            pi1_op_o   <= OP_RD;
            pi1_addr_o <= src_i;
          end
        end
        RDREQ: if (acc) pi1_op_o <= OP_NOP;
        RDDATA: if (pi1_rdy_i) begin
          pi1_data_o <= pi1_data_i;
          pi1_op_o   <= OP_WR;
          pi1_addr_o <= dst;
        end
        // The next read is issued straight from the write acceptance to keep 3 cycles per word.
        WRREQ: if (acc) begin
          rem_o      <= rem_o - 1'b1;
          src        <= src + 1'b1;
          dst        <= dst + 1'b1;
          pi1_op_o   <= last ? OP_NOP : OP_RD;
          pi1_addr_o <= src + 1'b1;
        end
        DRAIN: if (pi1_rdy_i) begin
          busy_o    <= 1'b0;
          done_o    <= 1'b1;
          aborted_o <= abort_q;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_smem_copy.sv
// tb_smem_copy: randomized scoreboard bench for smem_copy against a word-copy reference model.
module tb_smem_copy;
  localparam int AW = 30;
  localparam int MASK = (1 << AW) - 1;
  localparam logic [1:0] WR = 2'b01, RD = 2'b10;
  logic clk = 0, rst = 0, start = 0, abort = 0;
  logic [AW-1:0] src = 0, dst = 0;
  logic [15:0] len = 0;
  logic busy, done, aborted, rdy;
  logic [15:0] rem;
  logic [1:0] op;
  logic [AW-1:0] addr;
  logic [31:0] wdata, rdata = 0;
  logic [3:0] sel;
  always #5 clk = ~clk;
  smem_copy dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
    .src_i(src), .dst_i(dst), .len_i(len),
    .busy_o(busy), .done_o(done), .aborted_o(aborted), .rem_o(rem),
    .pi1_op_o(op), .pi1_addr_o(addr), .pi1_data_o(wdata), .pi1_data_i(rdata),
    .pi1_sel_o(sel), .pi1_rdy_i(rdy)
  );
  typedef struct {int n; int rem; int ab; int ed; int busy_n; int lrd; int lwr;} exp_t;
  exp_t q[$];
  logic [31:0] ref_mem [int];
  logic [31:0] mem [int];
  int dmin = 0, dmax = 0, cnt = 0, ecnt = 0, rd_n = 0, wr_n = 0, busy_c = 0;
  int last_rd = 0, last_wr = 0, done_total = 0, total = 0, bad = 0;
  logic pend = 0, prev_done = 0;
  logic [1:0] p_op = 0;
  logic [AW-1:0] p_addr = 0;
  logic [31:0] p_data = 0;
  task automatic check(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  // Slave memory with a random post-accept busy window of dmin..dmax cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mem = ref_mem;
      cnt = 0;
      rdy <= 1'b1;
    end else if (cnt != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) rdy <= 1'b1;
    end else if (op != 2'b00 && rdy) begin
      if (op == WR) mem[int'(addr)] = wdata;
      else rdata <= mem.exists(int'(addr)) ? mem[int'(addr)] : 32'h0;
      cnt = $urandom_range(dmax, dmin);
      if (cnt != 0) rdy <= 1'b0;
    end
  end
  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    pend <= !rst && op != 2'b00 && !rdy;
    p_op <= op;
    p_addr <= addr;
    p_data <= wdata;
    if (start) begin
      rd_n <= 0;
      wr_n <= 0;
      busy_c <= 0;
    end else begin
      if (op == RD && rdy) begin rd_n <= rd_n + 1; last_rd <= int'(addr); end
      if (op == WR && rdy) begin wr_n <= wr_n + 1; last_wr <= int'(addr); end
      if (busy) busy_c <= busy_c + 1;
    end
  end
  always @(negedge clk) begin
    exp_t e;
    int m;
    if (rst) begin
      check("rst_op", op, 0);
      check("rst_addr", addr, 0);
      check("rst_data", wdata, 0);
      check("rst_sel", sel, 15);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_aborted", aborted, 0);
      check("rst_rem", rem, 0);
    end else begin
      if (pend) begin
        check("hold_op", op, p_op);
        check("hold_addr", addr, p_addr);
        check("hold_data", wdata, p_data);
      end
      if (done) begin
        check("done_single", prev_done, 0);
        check("done_expected", q.size() > 0, 1);
        if (!prev_done && q.size() > 0) begin
          e = q.pop_front();
          done_total++;
          if (e.rem >= 0) check("rem", rem, e.rem);
          check("aborted", aborted, e.ab);
          check("busy_at_done", busy, 0);
          check("rd_count", rd_n, e.n);
          check("wr_count", wr_n, e.n);
          if (e.ed >= 0) check("done_edge", ecnt, e.ed);
          if (e.busy_n >= 0) check("busy_cycles", busy_c, e.busy_n);
          if (e.n > 0) begin
            check("last_rd_addr", last_rd, e.lrd);
            check("last_wr_addr", last_wr, e.lwr);
          end
          m = (mem.num() != ref_mem.num()) ? 1 : 0;
          foreach (ref_mem[a]) if (!mem.exists(a) || mem[a] !== ref_mem[a]) m++;
          check("mem_mismatches", m, 0);
        end
      end
    end
    prev_done = done;
  end
  task automatic run(input int s, input int d, input int l, input int dlo, input int dhi, input int k);
    exp_t e;
    int n, t, tgt;
    n = k != 0 ? k : l;
    for (int i = 0; i < n; i++) begin
      int sa;
      sa = (s + i) & MASK;
      ref_mem[(d + i) & MASK] = ref_mem.exists(sa) ? ref_mem[sa] : 32'h0;
    end
    e.n = n;
    e.rem = l == 0 ? -1 : l - n;
    e.ab = k != 0 ? 1 : 0;
    e.ed = dhi == 0 ? ecnt + 1 + (l == 0 ? 0 : 3 * n + 1) : -1;
    e.busy_n = l == 0 ? 0 : (dhi == 0 ? 3 * n + 1 : -1);
    e.lrd = (s + n - 1) & MASK;
    e.lwr = (d + n - 1) & MASK;
    q.push_back(e);
    dmin = dlo;
    dmax = dhi;
    tgt = done_total + 1;
    src = s[AW-1:0];
    dst = d[AW-1:0];
    len = l[15:0];
    start = 1;
    @(negedge clk);
    start = 0;
    t = 0;
    if (k != 0) begin
      while (rd_n != k && t < 1000) begin @(negedge clk); t++; end
      abort = 1;
      @(negedge clk);
      abort = 0;
    end
    while (done_total < tgt && t < 2000) begin @(negedge clk); t++; end
    if (done_total < tgt) begin
      $display("FAIL timeout: done_o not seen within bound (bad=%0d)", bad);
      $fatal(1, "transfer timed out");
    end
    @(negedge clk);
  endtask
  initial begin
    int l, k;
    for (int a = 0; a < 128; a++) ref_mem[a] = $urandom;
    for (int a = MASK - 3; a <= MASK; a++) ref_mem[a] = $urandom;
    #2 rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    run('h10, 'h40, 4, 0, 0, 0);
    run('h10, 'h40, 4, 2, 2, 0);
    run('h18, 'h48, 0, 0, 0, 0);
    run('h20, 'h60, 10, 0, 0, 3);
    run('h30, 'h70, 2, 0, 0, 0);
    run(MASK, 'h08, 2, 0, 0, 0);
    dmin = 0;
    dmax = 0;
    src = 'h05;
    dst = 'h45;
    len = 5;
    start = 1;
    @(negedge clk);
    start = 0;
    @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    run('h05, 'h45, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      l = $urandom_range(8, 0);
      k = (l > 0 && $urandom_range(3, 0) == 0) ? $urandom_range(l, 1) : 0;
      run($urandom_range(100, 0), $urandom_range(100, 0), l, 0, $urandom_range(3, 0), k);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
